// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: LSB-first data, one-cycle done pulse, framing flag.
// Optional parity bit check when UART_RX_PARITY_EN is defined (adds PARITY_ODD and parity_err).
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  // Tick counter must reach SB_TICK-1, which is 31 for two stop bits.
  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t          state_reg;
  logic [SW-1:0]   s_reg;
  logic [2:0]      n_reg;
  logic [DBIT-1:0] b_reg;
  logic [DBIT-1:0] dout_reg;
  logic            done_reg;
  logic            frame_err_reg;
  logic [1:0]      sync_reg;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_reg;
  logic            parity_err_reg;
`endif

  // Two-flop synchronizer; reset to the idle-high line level.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg      <= ST_IDLE;
      s_reg          <= '0;
      n_reg          <= '0;
      b_reg          <= '0;
      dout_reg       <= '0;
      done_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Start edge is taken on any clock, so back-to-back frames re-arm at once.
          if (!rx_s) begin
            state_reg <= ST_START;
            s_reg     <= '0;
          end
        end

        ST_START: begin
          if (s_tick) begin
            if (s_reg == SW'(7)) begin
              if (!rx_s) begin
                state_reg <= ST_DATA;
                s_reg     <= '0;
                n_reg     <= '0;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              s_reg <= s_reg + SW'(1);
            end
          end
        end

        ST_DATA: begin
          if (s_tick) begin
            if (s_reg == SW'(15)) begin
              b_reg <= {rx_s, b_reg[DBIT-1:1]};
              s_reg <= '0;
              if (n_reg == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= ST_PARITY;
`else
                state_reg <= ST_STOP;
`endif
              end else begin
                n_reg <= n_reg + 3'd1;
              end
            end else begin
              s_reg <= s_reg + SW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s_reg == SW'(15)) begin
              par_bit_reg <= rx_s;
              s_reg       <= '0;
              state_reg   <= ST_STOP;
            end else begin
              s_reg <= s_reg + SW'(1);
            end
          end
        end
`endif

        ST_STOP: begin
          if (s_tick) begin
            if (s_reg == SW'(SB_TICK - 1)) begin
              // A bad stop bit still delivers the word, flagged as a framing error.
              state_reg      <= ST_IDLE;
              dout_reg       <= b_reg;
              frame_err_reg  <= ~rx_s;
              done_reg       <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_reg <= (^b_reg) ^ par_bit_reg ^ PARITY_ODD;
`endif
            end else begin
              s_reg <= s_reg + SW'(1);
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dout         = dout_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = frame_err_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial-line driver pushes expected words, a monitor checks pulses.
// Exercises the parity path as well when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PODD    = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
`endif

  typedef struct {
    logic [7:0] data;
    bit         ferr;
    bit         perr;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   tick_div    = 16;
  int   frame_no    = 0;

  uart_rx #(
    .DBIT(DBIT),
    .SB_TICK(SB_TICK)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD(PODD)
`endif
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .rx(rx),
    .s_tick(s_tick),
    .dout(dout),
    .rx_done_tick(rx_done_tick),
    .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one pulse every tick_div clocks; tick_div==1 holds s_tick high.
  initial begin
    int cnt;
    cnt    = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      if (cnt >= tick_div) begin
        cnt    = 0;
        s_tick = 1'b1;
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * tick_div) @(negedge clk);
  endtask

  // Drives one frame on the line; a bad stop bit is held low for 13 ticks only.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                            input bit par_flip, input int gap_bits);
    exp_t e;
    e.data = data;
    e.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
    e.perr = par_flip;
`else
    e.perr = 1'b0;
`endif
    sb.push_back(e);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < DBIT; i++) begin
      rx = data[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ PODD ^ par_flip;
    wait_ticks(16);
`endif
    if (stop_ok) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      rx = 1'b0;
      wait_ticks(13);
      rx = 1'b1;
      wait_ticks(3);
    end
    wait_ticks(16 * gap_bits);
  endtask

  // Monitor: pops on every done pulse, and flags output changes outside a pulse.
  initial begin
    exp_t       e;
    logic [7:0] prev_dout;
    logic       prev_ferr;
    logic       prev_done;
    prev_dout = '0;
    prev_ferr = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
      end else if (rx_done_tick) begin
        if (prev_done) begin
          check("pulse_width", 32'(rx_done_tick), 32'(0));
        end else if (sb.size() == 0) begin
          check("spurious_pulse", 32'(rx_done_tick), 32'(0));
        end else begin
          e = sb.pop_front();
          frame_no++;
          $display("frame %0d: dout=%02h frame_err=%0b (expected %02h/%0b)",
                   frame_no, dout, frame_err, e.data, e.ferr);
          check("dout", 32'(dout), 32'(e.data));
          check("frame_err", 32'(frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
          check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
        end
      end else if (dout !== prev_dout || frame_err !== prev_ferr) begin
        check("hold_outputs", {23'd0, frame_err, dout}, {23'd0, prev_ferr, prev_dout});
      end
      prev_dout = dout;
      prev_ferr = frame_err;
      prev_done = rx_done_tick;
    end
  end

  initial begin
    logic [7:0] v;
    bit         ok;
    int         gap;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_dout", 32'(dout), 32'(0));
    check("reset_done", 32'(rx_done_tick), 32'(0));
    check("reset_ferr", 32'(frame_err), 32'(0));
    rst_n = 1'b1;
    wait_ticks(16);

    send_frame(8'h55, 1'b1, 1'b0, 1);

    // Short low glitch: rejected at mid start bit, no pulse, dout held.
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(32);
    check("glitch_dout", 32'(dout), 32'(8'h55));

    send_frame(8'hA3, 1'b0, 1'b0, 1);
    send_frame(8'h0F, 1'b1, 1'b0, 1);

    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1);

    // Reset in the middle of data bit 4 of 0x3C.
    v  = 8'h3C;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      wait_ticks(16);
    end
    rx = v[4];
    wait_ticks(8);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_dout", 32'(dout), 32'(0));
    check("midreset_done", 32'(rx_done_tick), 32'(0));
    check("midreset_ferr", 32'(frame_err), 32'(0));
    rst_n = 1'b1;
    wait_ticks(16);
    send_frame(8'hC3, 1'b1, 1'b0, 1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1);
    send_frame(8'h07, 1'b1, 1'b1, 1);
`endif

    // Random frames at faster tick rates, including s_tick held high.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0:       tick_div = 1;
        1:       tick_div = 3;
        default: tick_div = 4;
      endcase
      v   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      gap = $urandom_range(0, 2);
      if (!ok && gap == 0) gap = 1;
      send_frame(v, ok, 1'($urandom_range(0, 1)), gap);
    end

    for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge clk);
    check("pending_frames", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
